// File: rtl/tiny16_uart_tx.sv
// tiny16_uart_tx: byte FIFO drained by an 8N1 serial transmitter at a fixed baud rate
module tiny16_uart_tx #(
  parameter int CLK_DIV = 1250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    DATA,
  input  logic                          WR,
  output logic                          READY,
  output logic                          TX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [15:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic tx_n, tick, push, pop;
  assign READY = COUNT != (AW+1)'(FIFO_DEPTH);
  assign BUSY = state != ST_IDLE || COUNT != '0;
  assign tick = baud == '0;
  assign push = WR && READY;
  // the end of a stop bit pops directly so consecutive frames have no idle gap
  assign pop = COUNT != '0 && (state == ST_IDLE || (state == ST_STOP && tick));
  always_comb begin
    state_n = state;
    idx_n = idx;
    shift_n = shift;
    baud_n = (tick || state == ST_IDLE) ? RELOAD : baud - 16'd1;
    case (state)
      ST_IDLE:  state_n = pop ? ST_START : ST_IDLE;
      ST_START: begin
        state_n = tick ? ST_DATA : ST_START;
        idx_n = tick ? 3'd0 : idx;
      end
      ST_DATA:  begin
        shift_n = tick ? shift >> 1 : shift;
        idx_n = tick ? idx + 3'd1 : idx;
        state_n = (tick && idx == 3'd7) ? ST_STOP : ST_DATA;
      end
      ST_STOP:  state_n = tick ? (pop ? ST_START : ST_IDLE) : ST_STOP;
      default:  state_n = ST_IDLE;
    endcase
    if (pop) shift_n = mem[rptr];
    tx_n = state_n == ST_START ? 1'b0 : state_n == ST_DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      TX <= 1'b1;
      wptr <= '0;
      rptr <= '0;
      COUNT <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      shift <= shift_n;
      TX <= tx_n;
      wptr <= push ? wptr + AW'(1) : wptr;
      rptr <= pop ? rptr + AW'(1) : rptr;
      COUNT <= COUNT + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST && push) mem[wptr] <= DATA;
  end
endmodule

// File: tb/tb_tiny16_uart_tx.sv
// tb_tiny16_uart_tx: directed and random stimulus checked against a frame-level model
module tb_tiny16_uart_tx;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst [2];
  logic wr [2];
  logic [7:0] data [2];
  logic ready [2];
  logic tx [2];
  logic busy [2];
  logic [2:0] count [2];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall [2];
  int rx [2][$];
  int starts [2][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int g, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] at edge %0d: got %0d, expected %0d", nm, g, cyc, act, exp);
    end
  endtask
  task automatic wait_idle(input int g);
    int i;
    i = 0;
    while (busy[g] && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", g, int'(busy[g]), 0);
  endtask
  task automatic clear_logs();
    for (int g = 0; g < 2; g++) begin
      rx[g].delete();
      starts[g].delete();
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV = g == 0 ? 4 : 1;
    tiny16_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(D)) dut (
      .CLK(clk), .RST(rst[g]), .DATA(data[g]), .WR(wr[g]),
      .READY(ready[g]), .TX(tx[g]), .BUSY(busy[g]), .COUNT(count[g])
    );
    // model: a queue of bytes plus the position inside the current 10-bit frame
    initial begin
      int n, p, dt, et;
      bit fly, dact, bp;
      logic [7:0] fb, rb;
      byte unsigned q[$];
      fly = 0;
      dact = 0;
      bp = 0;
      p = 0;
      dt = 0;
      fb = 0;
      rb = 0;
      forever begin
        @(posedge clk);
        #1;
        n = q.size();
        if (rst[g]) begin
          q.delete();
          fly = 0;
        end else begin
          if (fly && p < 10*DIV-1) p++;
          else if (n > 0) begin
            fb = q.pop_front();
            fly = 1;
            p = 0;
          end else fly = 0;
          if (wr[g] && n != D) q.push_back(data[g]);
        end
        if (!fly || p/DIV == 9) et = 1;
        else if (p/DIV == 0) et = 0;
        else et = int'(fb[p/DIV-1]);
        chk("tx", g, int'(tx[g]), et);
        chk("count", g, int'(count[g]), q.size());
        chk("ready", g, int'(ready[g]), int'(q.size() != D));
        chk("busy", g, int'(busy[g]), int'(fly || q.size() != 0));
        if (bp && !busy[g]) fall[g] = cyc;
        bp = busy[g];
        // independent line decoder sampling mid-bit
        if (rst[g]) dact = 0;
        else if (!dact) begin
          if (!tx[g]) begin
            dact = 1;
            dt = 0;
            starts[g].push_back(cyc);
          end
        end else begin
          dt++;
          if (dt == 9*DIV + DIV/2) begin
            dact = 0;
            rx[g].push_back(int'(rb));
          end else if (dt >= DIV && dt % DIV == DIV/2) rb[dt/DIV-1] = tx[g];
        end
      end
    end
  end
  initial begin
    int kw, n, t;
    int e3 [3] = '{'h01, 'h80, 'h55};
    int e6 [$];
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1;
      wr[g] = 1'b0;
      data[g] = 8'h00;
      fall[g] = 0;
    end
    wr[0] = 1'b1;
    data[0] = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      chk("rst_tx", 0, int'(tx[0]), 1);
      chk("rst_busy", 0, int'(busy[0]), 0);
      chk("rst_ready", 0, int'(ready[0]), 1);
      chk("rst_count", 0, int'(count[0]), 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    wr[0] = 1'b0;
    clear_logs();
    @(negedge clk);
    wr[0] = 1'b1;
    data[0] = 8'hA5;
    kw = cyc + 1;
    @(negedge clk);
    wr[0] = 1'b0;
    wait_idle(0);
    chk("a5_n", 0, rx[0].size(), 1);
    chk("a5_byte", 0, rx[0].size() > 0 ? rx[0][0] : -1, 'hA5);
    chk("a5_start", 0, starts[0].size() > 0 ? starts[0][0] - kw : -1, 1);
    chk("a5_busy_fall", 0, fall[0] - kw, 41);
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr[0] = 1'b1;
      data[0] = 8'(e3[i]);
    end
    @(negedge clk);
    wr[0] = 1'b0;
    wait_idle(0);
    chk("b2b_n", 0, rx[0].size(), 3);
    for (int i = 0; i < 3; i++) chk("b2b_byte", 0, rx[0].size() > i ? rx[0][i] : -1, e3[i]);
    for (int i = 1; i < 3; i++) chk("b2b_gap", 0, starts[0].size() > i ? starts[0][i] - starts[0][i-1] : -1, 40);
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr[0] = 1'b1;
      data[0] = 8'(8'h10 + i);
    end
    @(negedge clk);
    wr[0] = 1'b0;
    wait_idle(0);
    chk("ovf_n", 0, rx[0].size(), 5);
    for (int i = 0; i < 5; i++) chk("ovf_byte", 0, rx[0].size() > i ? rx[0][i] : -1, 'h10 + i);
    chk("ovf_count", 0, int'(count[0]), 0);
    clear_logs();
    @(negedge clk);
    wr[0] = 1'b1;
    data[0] = 8'hC3;
    kw = cyc + 1;
    @(negedge clk);
    data[0] = 8'h3C;
    @(negedge clk);
    wr[0] = 1'b0;
    while (cyc < kw + 17) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("mid_rst_tx", 0, int'(tx[0]), 1);
    chk("mid_rst_count", 0, int'(count[0]), 0);
    chk("mid_rst_busy", 0, int'(busy[0]), 0);
    repeat (100) @(negedge clk);
    chk("mid_rst_rx", 0, rx[0].size(), 0);
    chk("mid_rst_frames", 0, starts[0].size(), 1);
    clear_logs();
    n = 0;
    t = 0;
    while (n < 9 && t < 500) begin
      @(negedge clk);
      t++;
      if (ready[1]) begin
        wr[1] = 1'b1;
        data[1] = 8'($urandom);
        e6.push_back(int'(data[1]));
        n++;
      end else wr[1] = 1'b0;
    end
    chk("div1_writes", 1, n, 9);
    @(negedge clk);
    wr[1] = 1'b0;
    wait_idle(1);
    chk("div1_n", 1, rx[1].size(), 9);
    for (int i = 0; i < 9; i++) chk("div1_byte", 1, rx[1].size() > i ? rx[1][i] : -1, e6.size() > i ? e6[i] : -2);
    for (int i = 1; i < 9; i++) chk("div1_gap", 1, starts[1].size() > i ? starts[1][i] - starts[1][i-1] : -1, 10);
    chk("div1_busy", 1, int'(busy[1]), 0);
    repeat (600) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        wr[g] = $urandom_range(0, 3) == 0;
        data[g] = 8'($urandom);
        rst[g] = $urandom_range(0, 249) == 0;
      end
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      wr[g] = 1'b0;
      rst[g] = 1'b0;
    end
    @(negedge clk);
    wait_idle(0);
    wait_idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tiny16_uart_tx.md
Name: tiny16_uart_tx

Overview:
- Serial transmitter that consumes the tiny16 core's OUT byte port and drives a single UART TX pin (8N1).
- The core writes a byte with a one-cycle strobe. The byte goes into a small FIFO, and the FIFO drains at a fixed baud rate.
- Sits between the tiny16 top level and the board pin, next to the USB pull-up logic.
- Lets firmware emit bytes without cycle-accurate bit-banging.

Parameters:
- CLK_DIV, 1250, clock cycles per serial bit (12 MHz / 9600 baud). Legal range 1..65535.
- FIFO_DEPTH, 4, byte entries; power of two, minimum 2.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- DATA  input  8  byte to send (tiny16 OUT).
- WR  input  1  write strobe; one byte is offered per cycle while high.
- READY  output  1  FIFO not full; a write is accepted only when WR && READY.
- TX  output  1  serial line, idle high.
- BUSY  output  1  high while a frame is in flight or the FIFO is non-empty.
- COUNT  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST high at an edge):
  - TX=1, BUSY=0, READY=1, COUNT=0.
  - FSM returns to IDLE; FIFO pointers and the baud counter clear.
  - Reset wins over every other event in the same cycle.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Write accepted at an edge where WR && READY: DATA is stored and COUNT increments.
  - A write while full (READY=0) is silently dropped, with no state change. This holds even if a pop occurs in the same cycle; READY is evaluated before that edge.
  - Simultaneous accepted write and pop leaves COUNT unchanged.
  - READY = (COUNT != FIFO_DEPTH), registered-state based. It is low in the cycle after the FIFO fills.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If COUNT>0 at an edge, pop the head byte into the shift register, load the baud counter, go to START, and drive TX=0 from that edge.
  - START: TX=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: TX = shift[0], LSB first. Each bit is held CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: TX=1 for CLK_DIV cycles. At the final edge:
    - if COUNT>0, pop and enter START directly (no idle gap between frames);
    - otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*CLK_DIV cycles.
  - Latency: byte accepted at edge k into an empty FIFO with FSM in IDLE. The pop happens at edge k+1, and TX falls after edge k+1.
  - The baud counter counts CLK_DIV-1 down to 0. CLK_DIV=1 gives one cycle per bit.
- TX is driven directly from a flop (glitch-free).
- BUSY = (state != IDLE) || (COUNT != 0).
- Reset mid-frame: TX returns high at the reset edge, the partial frame is abandoned, and queued bytes are discarded.
- WR held high while READY=1 writes the same DATA once per cycle. This is intended; the core issues one-cycle strobes.

Test Plan:
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
1. Reset hold:
   - Assert RST 4 cycles with WR=1, DATA=0xFF.
   - Require TX=1, BUSY=0, READY=1, COUNT=0 throughout, and no write captured.
2. Single byte:
   - WR one cycle with DATA=0xA5 at edge k.
   - Require TX low from edge k+1 for 4 cycles.
   - Then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles.
   - BUSY falls at edge k+41.
3. Back-to-back:
   - Write 0x01, 0x80, 0x55 on consecutive cycles.
   - Require three frames of 40 cycles each with no idle cycle between stop and next start, and decoded bytes 0x01, 0x80, 0x55 in order.
4. Overflow:
   - Write 0x10..0x15 on 6 consecutive cycles starting while IDLE.
   - Require 0x10..0x14 transmitted, 0x15 dropped, READY=0 for exactly the cycles where COUNT=4, and COUNT returning to 0 afterwards.
5. Reset mid-frame:
   - Queue 0xC3, 0x3C.
   - Assert RST for 1 cycle during data bit 3 of the first frame.
   - Require TX=1 from that edge, COUNT=0, and no further frames.
6. Divider edge and wrap:
   - Re-run with CLK_DIV=1.
   - Write 9 bytes paced by READY.
   - Require 10-cycle frames, correct order across pointer wrap-around, and final BUSY=0.
